frame_pattern_gen: RTL
======================

// Module: frame_pattern_gen
// PURPOSE
//  Downstream of the frame timing generator: consumes fval/lval/dval and produces a
//  registered test-pattern pixel stream with re-aligned fval/lval/dval.
//  Tracks column/row/frame counters, checks line length and row count against
//  DVAL_HIGH/ROW_COUNT, and pulses error flags on mismatch.
// PARAMETERS
//  PIXEL_WIDTH  8    pixel bit width (>=3)
//  DVAL_HIGH    640  expected valid pixels per line; must be a multiple of 8
//  ROW_COUNT    480  expected lines per frame
//  CHK_LOG2     5    checkerboard square size = 2**CHK_LOG2 pixels
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous active-high reset
//  fval_in        in   1   frame valid from the timing generator
//  lval_in        in   1   line valid from the timing generator
//  dval_in        in   1   data valid from the timing generator
//  pattern_sel    in   3   pattern request, latched at frame start
//  fval_out       out  1   fval_in delayed by 1 cycle (gated by state)
//  lval_out       out  1   lval_in delayed by 1 cycle (gated by state)
//  dval_out       out  1   gated dval delayed by 1 cycle
//  pixel_out      out  PIXEL_WIDTH  pattern pixel; 0 when dval_out=0
//  col_idx        out  16  column of the current pixel_out
//  row_idx        out  16  row of the current pixel_out
//  frame_cnt      out  16  completed frames, wraps at 0xFFFF->0
//  err_short_line out  1   1-cycle pulse: line ended with < DVAL_HIGH pixels
//  err_long_line  out  1   1-cycle pulse: line ended with > DVAL_HIGH pixels
//  err_row_count  out  1   1-cycle pulse: frame ended with rows != ROW_COUNT
// BEHAVIOUR
//  - Reset: all outputs, counters and input samples = 0; state = IDLE.
//  - Edges: detected from inputs vs 1-cycle registered samples of the inputs.
//  - FSM: IDLE (wait fval_in=0) -> WAIT_FRAME; WAIT_FRAME (fval_in rise) -> ACTIVE;
//    ACTIVE (fval_in fall) -> WAIT_FRAME. Outside ACTIVE, all outputs except
//    frame_cnt are 0. The fval_in rise cycle counts as ACTIVE for output purposes.
//    Releasing reset mid-frame never emits a partial frame.
//  - gdval = dval_in & lval_in & fval_in. A dval_in with lval or fval low is ignored.
//  - Frame start (fval rise): latch pattern_sel into active_pat; row = 0. A
//    pattern_sel change mid-frame has no effect until the next frame.
//  - Line start (lval rise): x = 0, bar_idx = 0, bar_cnt = 0.
//  - Each gdval cycle: x += 1, saturating at 0xFFFF. bar_cnt counts to
//    BAR_W-1 = DVAL_HIGH/8-1, then wraps and bar_idx += 1, saturating at 7.
//  - Line end (lval fall, ACTIVE): row += 1 if line had >=1 gdval, saturating.
//    If x < DVAL_HIGH: err_short_line. If x > DVAL_HIGH: err_long_line.
//  - Frame end (fval fall, ACTIVE): frame_cnt += 1.
//    If rows != ROW_COUNT: err_row_count. An lval fall in the same cycle is
//    processed first.
//  - Error pulses are registered, high exactly 1 cycle after the edge cycle.
//  - Latency is 1 cycle. Outputs at cycle n+1 reflect inputs and counter values
//    at cycle n: col_idx = x, row_idx = row, before the increment.
//  - Patterns (truncate to PIXEL_WIDTH LSBs):
//    0 = x; 1 = row; 2 = bar_idx << (PIXEL_WIDTH-3);
//    3 = (x[CHK_LOG2]^row[CHK_LOG2]) ? all-ones : 0; 4 = frame_cnt; 5 = x+row;
//    6,7 = all-ones.
// TESTING
//  Default bench params: PW=8, DVAL_HIGH=16, ROW_COUNT=4, CHK_LOG2=2.
//  - Pattern 0, 4 lines x 16 gdval -> pixel_out 0..15 per line, 1 cycle after
//    dval_in; no errors; frame_cnt 0->1.
//  - Pattern 2 -> pixels 0,0,32,32,64,64,...,224,224 on each line.
//  - Pattern 3, ROW_COUNT=8 -> rows 0-3: x0-3=0x00, x4-7=0xFF, ...;
//    rows 4-7 inverted.
//  - Line of 15 pixels -> err_short_line for 1 cycle; 17 -> err_long_line;
//    frame of 3 lines -> err_row_count 1 cycle after fval fall.
//  - pattern_sel 0->1 mid-frame -> frame stays pattern 0; next frame = row values.
//  - Reset released with fval_in=1 mid-frame -> outputs 0 until fval_in falls
//    and rises; then a full clean frame is emitted.

Source files
------------

// File: rtl/frame_pattern_gen_if.sv
// Timing inputs, pattern select and the re-aligned pattern stream of frame_pattern_gen.
// The master drives timing and pattern_sel; the slave (generator) drives the stream and flags.
interface frame_pattern_gen_if #(
   parameter int PIXEL_WIDTH = 8
);
   logic                   fval_in;
   logic                   lval_in;
   logic                   dval_in;
   logic [2:0]             pattern_sel;
   logic                   fval_out;
   logic                   lval_out;
   logic                   dval_out;
   logic [PIXEL_WIDTH-1:0] pixel_out;
   logic [15:0]            col_idx;
   logic [15:0]            row_idx;
   logic [15:0]            frame_cnt;
   logic                   err_short_line;
   logic                   err_long_line;
   logic                   err_row_count;

   modport master (
      output fval_in, lval_in, dval_in, pattern_sel,
      input  fval_out, lval_out, dval_out, pixel_out, col_idx, row_idx, frame_cnt,
             err_short_line, err_long_line, err_row_count
   );

   modport slave (
      input  fval_in, lval_in, dval_in, pattern_sel,
      output fval_out, lval_out, dval_out, pixel_out, col_idx, row_idx, frame_cnt,
             err_short_line, err_long_line, err_row_count
   );
endinterface

// File: rtl/frame_pattern_gen.sv
// Test-pattern pixel generator driven by fval/lval/dval timing, with one cycle of latency,
// column/row/frame tracking and line-length / row-count error pulses.
module frame_pattern_gen #(
   parameter int PIXEL_WIDTH = 8,
   parameter int DVAL_HIGH   = 640,
   parameter int ROW_COUNT   = 480,
   parameter int CHK_LOG2    = 5
) (
   input logic              clk,
   input logic              rst,
   frame_pattern_gen_if.slave bus
);
   localparam int          BAR_W    = DVAL_HIGH / 8;
   localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);
   localparam logic [15:0] DVAL_LIM = 16'(DVAL_HIGH);
   localparam logic [15:0] ROW_LIM  = 16'(ROW_COUNT);

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

   state_t                 state;
   logic                   fval_q, lval_q;
   logic [15:0]            x, row, bar_cnt;
   logic [2:0]             bar_idx, active_pat;

   logic                   fval_rise, fval_fall, lval_rise, lval_fall;
   logic                   frame_start, active, gdval, gd, line_end, frame_end;
   logic [15:0]            x_cur, x_next, row_cur, row_end, bar_cnt_cur, bar_cnt_next;
   logic [2:0]             bar_cur, bar_next, pat_cur;
   logic [PIXEL_WIDTH-1:0] pix;

   // Values at line/frame start are forced to their start values combinationally so
   // a pixel arriving on the same cycle as the lval/fval rise sees x=0 / row=0.
   always_comb begin
      fval_rise   = bus.fval_in & ~fval_q;
      fval_fall   = ~bus.fval_in & fval_q;
      lval_rise   = bus.lval_in & ~lval_q;
      lval_fall   = ~bus.lval_in & lval_q;
      frame_start = (state == WAIT_FRAME) && fval_rise;
      active      = (state == ACTIVE) || frame_start;
      gdval       = bus.dval_in & bus.lval_in & bus.fval_in;
      gd          = active & gdval;
      line_end    = active & lval_fall;
      frame_end   = (state == ACTIVE) && fval_fall;

      x_cur       = (active && lval_rise) ? '0 : x;
      bar_cur     = (active && lval_rise) ? '0 : bar_idx;
      bar_cnt_cur = (active && lval_rise) ? '0 : bar_cnt;
      row_cur     = frame_start ? '0 : row;
      pat_cur     = frame_start ? bus.pattern_sel : active_pat;

      x_next       = x_cur;
      bar_next     = bar_cur;
      bar_cnt_next = bar_cnt_cur;
      if (gd) begin
         if (x_cur != 16'hFFFF) x_next = x_cur + 16'd1;
         if (bar_cnt_cur == BAR_LAST) begin
            bar_cnt_next = '0;
            if (bar_cur != 3'd7) bar_next = bar_cur + 3'd1;
         end else begin
            bar_cnt_next = bar_cnt_cur + 16'd1;
         end
      end

      row_end = row_cur;
      if (line_end && x_cur != '0 && row_cur != 16'hFFFF) row_end = row_cur + 16'd1;

      case (pat_cur)
         3'd0:    pix = PIXEL_WIDTH'(x_cur);
         3'd1:    pix = PIXEL_WIDTH'(row_cur);
         3'd2:    pix = PIXEL_WIDTH'(bar_cur) << (PIXEL_WIDTH - 3);
         3'd3:    pix = (x_cur[CHK_LOG2] ^ row_cur[CHK_LOG2]) ? '1 : '0;
         3'd4:    pix = PIXEL_WIDTH'(bus.frame_cnt);
         3'd5:    pix = PIXEL_WIDTH'(x_cur + row_cur);
         default: pix = '1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         fval_q             <= 1'b0;
         lval_q             <= 1'b0;
         x                  <= '0;
         row                <= '0;
         bar_cnt            <= '0;
         bar_idx            <= '0;
         active_pat         <= '0;
         bus.fval_out       <= 1'b0;
         bus.lval_out       <= 1'b0;
         bus.dval_out       <= 1'b0;
         bus.pixel_out      <= '0;
         bus.col_idx        <= '0;
         bus.row_idx        <= '0;
         bus.frame_cnt      <= '0;
         bus.err_short_line <= 1'b0;
         bus.err_long_line  <= 1'b0;
         bus.err_row_count  <= 1'b0;
      end else begin
         fval_q             <= bus.fval_in;
         lval_q             <= bus.lval_in;
         bus.err_short_line <= 1'b0;
         bus.err_long_line  <= 1'b0;
         bus.err_row_count  <= 1'b0;

         case (state)
            IDLE:       if (!bus.fval_in) state <= WAIT_FRAME;
            WAIT_FRAME: if (fval_rise) state <= ACTIVE;
            ACTIVE:     if (fval_fall) state <= WAIT_FRAME;
            default:    state <= IDLE;
         endcase

         if (active) begin
            x          <= x_next;
            bar_idx    <= bar_next;
            bar_cnt    <= bar_cnt_next;
            row        <= row_end;
            active_pat <= pat_cur;
         end

         if (line_end) begin
            bus.err_short_line <= (x_cur < DVAL_LIM);
            bus.err_long_line  <= (x_cur > DVAL_LIM);
         end

         if (frame_end) begin
            bus.frame_cnt     <= bus.frame_cnt + 16'd1;
            bus.err_row_count <= (row_end != ROW_LIM);
         end

         bus.fval_out  <= active & bus.fval_in;
         bus.lval_out  <= active & bus.lval_in;
         bus.dval_out  <= gd;
         bus.pixel_out <= gd ? pix : '0;
         bus.col_idx   <= active ? x_cur : '0;
         bus.row_idx   <= active ? row_cur : '0;
      end
   end
endmodule
